// File: rtl/tdc_meas_ctrl_if.sv
// Command and result bus between the host register block and tdc_meas_ctrl.
// The host side is the master; the measurement controller is the slave.
interface tdc_meas_ctrl_if #(
  parameter int HW_W     = 7,
  parameter int CNT_W    = 8,
  parameter int SETTLE_W = 4
);
  logic                   start;
  logic                   abort;
  logic [CNT_W-1:0]       n_samples;
  logic [SETTLE_W-1:0]    settle;
  logic                   cfg_src;
  logic                   cfg_bypass;
  logic                   res_valid;
  logic                   res_ready;
  logic [HW_W+CNT_W-1:0]  res_sum;
  logic [HW_W-1:0]        res_min;
  logic [HW_W-1:0]        res_max;

  modport master (
    output start, abort, n_samples, settle, cfg_src, cfg_bypass, res_ready,
    input  res_valid, res_sum, res_min, res_max
  );

  modport slave (
    input  start, abort, n_samples, settle, cfg_src, cfg_bypass, res_ready,
    output res_valid, res_sum, res_min, res_max
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the hamming-weight TDC: issues N launch edges,
// samples the core after a settle delay and reports sum/min/max of the run.
module tdc_meas_ctrl #(
  parameter int HW_W     = 7,
  parameter int CNT_W    = 8,
  parameter int SETTLE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  tdc_meas_ctrl_if.slave  bus,
  input  logic [HW_W-1:0] hw_in_i,
  output logic            pg_tog_o,
  output logic            pg_src_o,
  output logic            pg_bypass_o,
  output logic            busy_o
);

  localparam int SUM_W = HW_W + CNT_W;
  localparam logic [CNT_W:0]    N_MAX      = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]    CNT_ONE    = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SAMPLE,
    S_RESULT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W:0]      n_eff_q, n_eff_d;
  logic [CNT_W:0]      count_q, count_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] wait_q, wait_d;
  logic                tog_q, tog_d;
  logic                src_q, src_d;
  logic                byp_q, byp_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [HW_W-1:0]     min_q, min_d;
  logic [HW_W-1:0]     max_q, max_d;
  logic [CNT_W:0]      count_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_eff_q  <= '0;
      count_q  <= '0;
      settle_q <= '0;
      wait_q   <= '0;
      tog_q    <= 1'b0;
      src_q    <= 1'b0;
      byp_q    <= 1'b0;
      sum_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_eff_q  <= n_eff_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      tog_q    <= tog_d;
      src_q    <= src_d;
      byp_q    <= byp_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
    end
  end

  // Abort in any active measuring state drops straight to IDLE and leaves
  // pg_tog where it is, so the next run still alternates edge polarity.
  always_comb begin
    state_d   = state_q;
    n_eff_d   = n_eff_q;
    count_d   = count_q;
    settle_d  = settle_q;
    wait_d    = wait_q;
    tog_d     = tog_q;
    src_d     = src_q;
    byp_d     = byp_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    count_inc = count_q + CNT_ONE;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_eff_d  = (bus.n_samples == '0) ? N_MAX : {1'b0, bus.n_samples};
          settle_d = (bus.settle == '0) ? SETTLE_ONE : bus.settle;
          src_d    = bus.cfg_src;
          byp_d    = bus.cfg_bypass;
          count_d  = '0;
          sum_d    = '0;
          min_d    = '1;
          max_d    = '0;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          tog_d   = ~tog_q;
          wait_d  = settle_q;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - SETTLE_ONE;
          if (wait_q == SETTLE_ONE) begin
            state_d = S_SAMPLE;
          end
        end
      end

      // Sum width leaves room for 2^CNT_W full-scale samples.
      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          sum_d   = sum_q + {{CNT_W{1'b0}}, hw_in_i};
          min_d   = (hw_in_i < min_q) ? hw_in_i : min_q;
          max_d   = (hw_in_i > max_q) ? hw_in_i : max_q;
          count_d = count_inc;
          state_d = (count_inc == n_eff_q) ? S_RESULT : S_LAUNCH;
        end
      end

      S_RESULT: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q != S_IDLE);
  assign pg_tog_o      = tog_q;
  assign pg_src_o      = src_q;
  assign pg_bypass_o   = byp_q;
  assign bus.res_valid = (state_q == S_RESULT);
  assign bus.res_sum   = sum_q;
  assign bus.res_min   = min_q;
  assign bus.res_max   = max_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: a table of complete runs with
// hand-computed results, plus directed abort / reset / hold sequences.
module tb_tdc_meas_ctrl;
  localparam int HW_W     = 7;
  localparam int CNT_W    = 8;
  localparam int SETTLE_W = 4;

  typedef struct {
    string name;
    int    nSamples;
    int    settle;
    int    src;
    int    byp;
    int    hwConst;
    int    expSum;
    int    expMin;
    int    expMax;
    int    expToggles;
    int    expLatency;
    int    expSpacing;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [HW_W-1:0] hw_in;
  logic            pg_tog;
  logic            pg_src;
  logic            pg_bypass;
  logic            busy;

  int   checks   = 0;
  int   failures = 0;
  int   hwSeq [8];
  bit   useSeq;
  int   obsLatency;
  int   obsToggles;
  int   obsSpacingErr;
  int   obsSrc1;
  int   obsByp1;
  bit   obsSawValid;
  vec_t vecs [5];
  vec_t v;

  tdc_meas_ctrl_if #(.HW_W(HW_W), .CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) bus ();

  tdc_meas_ctrl #(.HW_W(HW_W), .CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .hw_in_i     (hw_in),
    .pg_tog_o    (pg_tog),
    .pg_src_o    (pg_src),
    .pg_bypass_o (pg_bypass),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses start and steps on negedges until res_valid or the budget runs out.
  // Cycle k is the negedge after the k-th posedge following the start pulse.
  task automatic applyStimulus(input vec_t tv, input int extraStartCycle,
                               input int abortCycle, input int budget);
    int   cycle;
    int   lastToggleCycle;
    logic lastTog;
    @(negedge clk);
    bus.n_samples  = CNT_W'(tv.nSamples);
    bus.settle     = SETTLE_W'(tv.settle);
    bus.cfg_src    = tv.src[0];
    bus.cfg_bypass = tv.byp[0];
    bus.res_ready  = 1'b0;
    bus.start      = 1'b1;
    hw_in          = useSeq ? HW_W'(hwSeq[0]) : HW_W'(tv.hwConst);
    lastTog         = pg_tog;
    lastToggleCycle = 0;
    cycle           = 0;
    obsToggles      = 0;
    obsSpacingErr   = 0;
    obsSawValid     = 1'b0;
    obsLatency      = -1;
    do begin
      @(negedge clk);
      cycle++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (cycle == 1) begin
        obsSrc1 = int'(pg_src);
        obsByp1 = int'(pg_bypass);
      end
      if (pg_tog !== lastTog) begin
        obsToggles++;
        if (obsToggles > 1 && (cycle - lastToggleCycle) != tv.expSpacing) obsSpacingErr++;
        lastToggleCycle = cycle;
        lastTog         = pg_tog;
        if (useSeq && obsToggles <= 8) hw_in = HW_W'(hwSeq[obsToggles-1]);
      end
      if (bus.res_valid === 1'b1) begin
        obsSawValid = 1'b1;
        obsLatency  = cycle;
      end
      if (cycle == extraStartCycle) bus.start = 1'b1;
      if (cycle == abortCycle) bus.abort = 1'b1;
    end while (!obsSawValid && cycle < budget);
  endtask

  task automatic completeHandshake(input string name);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, int'(bus.res_valid), 0);
    checkOutput({name, "_busy_drop"}, int'(busy), 0);
  endtask

  task automatic runAndCheck(input vec_t tv, input int extraStartCycle, input int holdCycles);
    applyStimulus(tv, extraStartCycle, -1, tv.expLatency + 20);
    checkOutput({tv.name, "_latency"}, obsLatency, tv.expLatency);
    checkOutput({tv.name, "_sum"}, int'(bus.res_sum), tv.expSum);
    checkOutput({tv.name, "_min"}, int'(bus.res_min), tv.expMin);
    checkOutput({tv.name, "_max"}, int'(bus.res_max), tv.expMax);
    checkOutput({tv.name, "_toggles"}, obsToggles, tv.expToggles);
    checkOutput({tv.name, "_spacing_err"}, obsSpacingErr, 0);
    checkOutput({tv.name, "_src"}, obsSrc1, tv.src);
    checkOutput({tv.name, "_bypass"}, obsByp1, tv.byp);
    checkOutput({tv.name, "_busy"}, int'(busy), 1);
    for (int k = 0; k < holdCycles; k++) begin
      @(negedge clk);
      checkOutput({tv.name, "_hold_valid"}, int'(bus.res_valid), 1);
      checkOutput({tv.name, "_hold_sum"}, int'(bus.res_sum), tv.expSum);
      checkOutput({tv.name, "_hold_max"}, int'(bus.res_max), tv.expMax);
    end
    completeHandshake(tv.name);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedTog;
    int extraToggles;
    int sawValid;
    int busyCycles;

    //         name        n    s   src byp hw   sum    min  max  tog  lat  sp
    vecs[0] = '{"basic",    4,   2,  0,  0,  37,  148,   37,  37,  4,   17,  4};
    vecs[1] = '{"n256",     0,   0,  0,  1,  127, 32512, 127, 127, 256, 769, 3};
    vecs[2] = '{"single",   1,   1,  1,  0,  0,   0,     0,   0,   1,   4,   3};
    vecs[3] = '{"settle15", 2,   15, 1,  1,  100, 200,   100, 100, 2,   35,  17};
    vecs[4] = '{"n255",     255, 1,  0,  0,  127, 32385, 127, 127, 255, 766, 3};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.n_samples  = '0;
    bus.settle     = '0;
    bus.cfg_src    = 1'b0;
    bus.cfg_bypass = 1'b0;
    bus.res_ready  = 1'b0;
    hw_in          = '0;
    useSeq         = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(bus.res_valid), 0);
    checkOutput("reset_tog", int'(pg_tog), 0);
    checkOutput("reset_min", int'(bus.res_min), 0);

    for (int i = 0; i < 5; i++) begin
      runAndCheck(vecs[i], -1, 0);
    end

    // Varying data with a stalled consumer.
    useSeq   = 1'b1;
    hwSeq[0] = 10;
    hwSeq[1] = 90;
    hwSeq[2] = 45;
    v = '{"vary", 3, 2, 0, 0, 0, 145, 10, 90, 3, 13, 4};
    runAndCheck(v, -1, 5);
    @(negedge clk);
    checkOutput("vary_idle_sum", int'(bus.res_sum), 145);
    checkOutput("vary_idle_min", int'(bus.res_min), 10);
    useSeq = 1'b0;

    // Second start during WAIT must not restart the run.
    v = '{"ignore_start", 3, 2, 1, 1, 20, 60, 20, 20, 3, 13, 4};
    runAndCheck(v, 2, 0);

    // Abort in the LAUNCH after the third SAMPLE.
    v = '{"abort", 8, 2, 0, 0, 50, 0, 0, 0, 0, 0, 4};
    applyStimulus(v, -1, 13, 14);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_toggles", obsToggles, 3);
    savedTog     = int'(pg_tog);
    extraToggles = 0;
    sawValid     = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (int'(pg_tog) != savedTog) extraToggles++;
      if (bus.res_valid === 1'b1) sawValid++;
    end
    checkOutput("abort_no_valid", sawValid, 0);
    checkOutput("abort_tog_held", extraToggles, 0);
    v = '{"after_abort", 1, 2, 0, 0, 5, 5, 5, 5, 1, 5, 4};
    runAndCheck(v, -1, 0);

    // Asynchronous reset in the middle of WAIT.
    v = '{"rst_run", 4, 5, 1, 1, 33, 0, 0, 0, 0, 0, 7};
    applyStimulus(v, -1, -1, 3);
    checkOutput("rst_pre_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_tog", int'(pg_tog), 0);
    checkOutput("rst_src", int'(pg_src), 0);
    checkOutput("rst_bypass", int'(pg_bypass), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(bus.res_valid), 0);
    checkOutput("rst_sum", int'(bus.res_sum), 0);
    checkOutput("rst_min", int'(bus.res_min), 0);
    checkOutput("rst_max", int'(bus.res_max), 0);
    @(negedge clk);
    rst          = 1'b0;
    extraToggles = 0;
    busyCycles   = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (pg_tog !== 1'b0) extraToggles++;
      if (busy !== 1'b0) busyCycles++;
    end
    checkOutput("rst_idle_tog", extraToggles, 0);
    checkOutput("rst_idle_busy", busyCycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
